uart_axil_slave: RTL

AXI4-Lite slave front end for the UART peripheral. It accepts single-beat AXI4-Lite reads and writes from the system interconnect. It converts each one into a one-cycle access on the UART register-file port (reg_addr/reg_wen/reg_ren, with same-cycle reg_rdata/reg_error), then returns the AXI response. It sits between the interconnect and the UART register file and handles one transaction at a time.

---
 rtl/uart_axil_slave.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/uart_axil_slave.sv
// AXI4-Lite slave that turns single-beat reads/writes into one-cycle UART register-file accesses.
// Handles one transaction at a time; AW/W may arrive in either order, and reads win ties in IDLE.
module uart_axil_slave #(
  parameter int ADDR_WIDTH     = 6,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int NUM_REGS       = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_WIDTH-1:0]     s_axil_awaddr,
  input  logic                      s_axil_awvalid,
  output logic                      s_axil_awready,
  input  logic [DATA_WIDTH-1:0]     s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axil_wstrb,
  input  logic                      s_axil_wvalid,
  output logic                      s_axil_wready,
  output logic [1:0]                s_axil_bresp,
  output logic                      s_axil_bvalid,
  input  logic                      s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axil_araddr,
  input  logic                      s_axil_arvalid,
  output logic                      s_axil_arready,
  output logic [DATA_WIDTH-1:0]     s_axil_rdata,
  output logic [1:0]                s_axil_rresp,
  output logic                      s_axil_rvalid,
  input  logic                      s_axil_rready,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0]     reg_wdata,
  output logic [DATA_WIDTH/8-1:0]   reg_wstrb,
  output logic                      reg_wen,
  output logic                      reg_ren,
  input  logic [DATA_WIDTH-1:0]     reg_rdata,
  input  logic                      reg_error
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_RESP,
    RD_ISSUE,
    RD_RESP
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      r_aw_held;
  logic                      r_w_held;
  logic                      r_oor;
  logic [REG_ADDR_WIDTH-1:0] r_reg_addr;
  logic [DATA_WIDTH-1:0]     r_reg_wdata;
  logic [STRB_W-1:0]         r_reg_wstrb;
  logic [1:0]                r_bresp;
  logic [1:0]                r_rresp;
  logic [DATA_WIDTH-1:0]     r_rdata;

  logic w_awready;
  logic w_wready;
  logic w_arready;
  logic w_bvalid;
  logic w_rvalid;
  logic w_wen;
  logic w_ren;
  logic w_rd_prio;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_ar_hs;

  function automatic logic [REG_ADDR_WIDTH-1:0] f_word_idx(input logic [ADDR_WIDTH-1:0] addr);
    f_word_idx = addr[REG_ADDR_WIDTH+1:2];
  endfunction

  // Any address bit above the word index, or an index past the last register, misses the file.
  function automatic logic f_out_of_range(input logic [ADDR_WIDTH-1:0] addr);
    logic [REG_ADDR_WIDTH-1:0] idx;
    idx = addr[REG_ADDR_WIDTH+1:2];
    f_out_of_range = ((addr >> (REG_ADDR_WIDTH + 2)) != '0) ||
                     (32'(idx) >= 32'(NUM_REGS));
  endfunction

  assign w_aw_hs = s_axil_awvalid && w_awready;
  assign w_w_hs  = s_axil_wvalid  && w_wready;
  assign w_ar_hs = s_axil_arvalid && w_arready;

  always_comb begin
    w_state_nxt = r_state;
    w_awready   = 1'b0;
    w_wready    = 1'b0;
    w_arready   = 1'b0;
    w_bvalid    = 1'b0;
    w_rvalid    = 1'b0;
    w_wen       = 1'b0;
    w_ren       = 1'b0;
    w_rd_prio   = s_axil_arvalid && !r_aw_held && !r_w_held;
    unique case (r_state)
      IDLE: begin
        w_awready = rst_n && !r_aw_held && !w_rd_prio;
        w_wready  = rst_n && !r_w_held && !w_rd_prio;
        w_arready = rst_n && !r_aw_held && !r_w_held;
        if (s_axil_arvalid && w_arready) begin
          w_state_nxt = RD_ISSUE;
        end else if ((r_aw_held || (s_axil_awvalid && w_awready)) &&
                     (r_w_held  || (s_axil_wvalid  && w_wready))) begin
          w_state_nxt = WR_ISSUE;
        end
      end
      WR_ISSUE: begin
        w_wen       = rst_n && !r_oor;
        w_state_nxt = WR_RESP;
      end
      WR_RESP: begin
        w_bvalid = 1'b1;
        if (s_axil_bready) w_state_nxt = IDLE;
      end
      RD_ISSUE: begin
        w_ren       = rst_n && !r_oor;
        w_state_nxt = RD_RESP;
      end
      RD_RESP: begin
        w_rvalid = 1'b1;
        if (s_axil_rready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_aw_held   <= 1'b0;
      r_w_held    <= 1'b0;
      r_oor       <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_reg_wstrb <= '0;
      r_bresp     <= RESP_OKAY;
      r_rresp     <= RESP_OKAY;
      r_rdata     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_aw_hs) begin
        r_aw_held  <= 1'b1;
        r_reg_addr <= f_word_idx(s_axil_awaddr);
        r_oor      <= f_out_of_range(s_axil_awaddr);
      end
      if (w_w_hs) begin
        r_w_held    <= 1'b1;
        r_reg_wdata <= s_axil_wdata;
        r_reg_wstrb <= s_axil_wstrb;
      end
      if (w_ar_hs) begin
        r_reg_addr <= f_word_idx(s_axil_araddr);
        r_oor      <= f_out_of_range(s_axil_araddr);
      end
      if (r_state == WR_ISSUE) begin
        r_bresp <= r_oor ? RESP_SLVERR : RESP_OKAY;
      end
      // Read data is captured in the strobe cycle; the file's output is only valid then.
      if (r_state == RD_ISSUE) begin
        r_rdata <= r_oor ? '0 : reg_rdata;
        r_rresp <= (r_oor || reg_error) ? RESP_SLVERR : RESP_OKAY;
      end
      if ((r_state == WR_RESP) && s_axil_bready) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
    end
  end

  assign s_axil_awready = w_awready;
  assign s_axil_wready  = w_wready;
  assign s_axil_arready = w_arready;
  assign s_axil_bvalid  = w_bvalid;
  assign s_axil_bresp   = r_bresp;
  assign s_axil_rvalid  = w_rvalid;
  assign s_axil_rresp   = r_rresp;
  assign s_axil_rdata   = r_rdata;
  assign reg_addr       = r_reg_addr;
  assign reg_wdata      = r_reg_wdata;
  assign reg_wstrb      = r_reg_wstrb;
  assign reg_wen        = w_wen;
  assign reg_ren        = w_ren;

endmodule
